// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared duty constants, sequencer state enum and duty clamp helper
package pwm_ctrl_pkg;

    localparam int DUTY_W     = 4;
    localparam int INTERVAL_W = 16;

    // Shared with the PWM generator so both sides leave reset at the same duty.
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(10);
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(5);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PULSE,
        GAP
    } ramp_state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// rtl/pwm_duty_ramp_ctrl_if.sv - target/manual request and strobe/status bundle; abort port under RAMP_ABORT_EN
interface pwm_duty_ramp_ctrl_if
    import pwm_ctrl_pkg::*;
();

    logic                  target_valid;
    logic [DUTY_W-1:0]     target_duty;
    logic                  target_ready;
    logic [INTERVAL_W-1:0] step_interval;
    logic                  manual_inc;
    logic                  manual_dec;
    logic                  inc_strobe;
    logic                  dec_strobe;
    logic [DUTY_W-1:0]     duty_shadow;
    logic                  busy;
    logic                  done;
`ifdef RAMP_ABORT_EN
    logic                  abort;
`endif

    modport master (
`ifdef RAMP_ABORT_EN
        output abort,
`endif
        output target_valid, target_duty, step_interval, manual_inc, manual_dec,
        input  target_ready, inc_strobe, dec_strobe, duty_shadow, busy, done
    );

    modport slave (
`ifdef RAMP_ABORT_EN
        input  abort,
`endif
        input  target_valid, target_duty, step_interval, manual_inc, manual_dec,
        output target_ready, inc_strobe, dec_strobe, duty_shadow, busy, done
    );

endinterface

// File: rtl/pwm_strobe_timer.sv
// rtl/pwm_strobe_timer.sv - loadable down-counter shared by interval wait and pulse/gap timing
module pwm_strobe_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - ramps PWM duty toward a target with paced inc/dec strobes; RAMP_ABORT_EN adds abort
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PULSE_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_ramp_ctrl_if.slave  bus
);

    // Timer runs from load value down to zero, so every phase loads its length minus one.
    localparam logic [INTERVAL_W-1:0] PULSE_LAST = INTERVAL_W'(PULSE_LEN - 1);

    ramp_state_t           state, state_n;
    logic [DUTY_W-1:0]     tgt, tgt_n, shadow, shadow_n, req_tgt;
    logic [INTERVAL_W-1:0] ivl, ivl_n, req_ivl, load_val;
    logic                  dir_up, dir_up_n;
    logic                  done_q, done_n;
    logic                  inc_q, dec_q;
    logic                  abort_pend, abort_pend_n, abort_req;
    logic                  load, zero;

`ifdef RAMP_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign req_tgt = clamp_duty(bus.target_duty);
    assign req_ivl = (bus.step_interval == '0) ? INTERVAL_W'(1) : bus.step_interval;

    pwm_strobe_timer #(.W(INTERVAL_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (state != IDLE),
        .zero     (zero)
    );

    always_comb begin
        state_n      = state;
        tgt_n        = tgt;
        ivl_n        = ivl;
        dir_up_n     = dir_up;
        shadow_n     = shadow;
        done_n       = 1'b0;
        abort_pend_n = abort_pend;
        load         = 1'b0;
        load_val     = '0;
        case (state)
            IDLE: begin
                abort_pend_n = 1'b0;
                if (bus.target_valid) begin
                    tgt_n = req_tgt;
                    ivl_n = req_ivl;
                    if (req_tgt == shadow) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = WAIT;
                        load     = 1'b1;
                        load_val = req_ivl - 1'b1;
                    end
                end else if (bus.manual_inc && !bus.manual_dec && (shadow < DUTY_MAX)) begin
                    tgt_n    = shadow + 1'b1;
                    shadow_n = shadow + 1'b1;
                    dir_up_n = 1'b1;
                    state_n  = PULSE;
                    load     = 1'b1;
                    load_val = PULSE_LAST;
                end else if (bus.manual_dec && !bus.manual_inc && (shadow != '0)) begin
                    tgt_n    = shadow - 1'b1;
                    shadow_n = shadow - 1'b1;
                    dir_up_n = 1'b0;
                    state_n  = PULSE;
                    load     = 1'b1;
                    load_val = PULSE_LAST;
                end
            end
            WAIT: begin
                if (abort_req) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (zero) begin
                    // tgt != shadow is guaranteed here, so the step never leaves [0, DUTY_MAX].
                    dir_up_n = (tgt > shadow);
                    shadow_n = dir_up_n ? shadow + 1'b1 : shadow - 1'b1;
                    state_n  = PULSE;
                    load     = 1'b1;
                    load_val = PULSE_LAST;
                end
            end
            PULSE: begin
                abort_pend_n = abort_pend | abort_req;
                if (zero) begin
                    state_n  = GAP;
                    load     = 1'b1;
                    load_val = PULSE_LAST;
                end
            end
            GAP: begin
                abort_pend_n = abort_pend | abort_req;
                if (zero) begin
                    if ((shadow == tgt) || abort_pend_n) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n  = WAIT;
                        load     = 1'b1;
                        load_val = ivl - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tgt        <= DUTY_INIT;
            ivl        <= INTERVAL_W'(1);
            dir_up     <= 1'b0;
            shadow     <= DUTY_INIT;
            done_q     <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_n;
            tgt        <= tgt_n;
            ivl        <= ivl_n;
            dir_up     <= dir_up_n;
            shadow     <= shadow_n;
            done_q     <= done_n;
            inc_q      <= (state_n == PULSE) && dir_up_n;
            dec_q      <= (state_n == PULSE) && !dir_up_n;
            abort_pend <= abort_pend_n;
        end
    end

    assign bus.target_ready = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.inc_strobe   = inc_q;
    assign bus.dec_strobe   = dec_q;
    assign bus.duty_shadow  = shadow;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - directed self-checking bench for pwm_duty_ramp_ctrl
module tb_pwm_duty_ramp_ctrl;

    localparam int C_INC_R  = 0;
    localparam int C_DEC_R  = 1;
    localparam int C_INC_HI = 2;
    localparam int C_DEC_HI = 3;
    localparam int C_DONE   = 4;
    localparam int C_BUSY   = 5;
    localparam int C_BOTH   = 6;
    localparam int C_RANGE  = 7;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_n   = 0;
    int man_n   = 0;
    int done_at = 0;
    int cnt[8]  = '{default: 0};
    int base[8] = '{default: 0};
    int rbase   = 0;
    int rise_t[$];
    logic inc_q = 1'b0;
    logic dec_q = 1'b0;

    pwm_duty_ramp_ctrl_if bus ();

    pwm_duty_ramp_ctrl #(.PULSE_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus.target_valid && bus.target_ready) acc_n = cyc;
        if ((bus.manual_inc || bus.manual_dec) && bus.target_ready) man_n = cyc;
        if (bus.inc_strobe && !inc_q) begin
            cnt[C_INC_R]++;
            rise_t.push_back(cyc);
        end
        if (bus.dec_strobe && !dec_q) begin
            cnt[C_DEC_R]++;
            rise_t.push_back(cyc);
        end
        if (bus.inc_strobe) cnt[C_INC_HI]++;
        if (bus.dec_strobe) cnt[C_DEC_HI]++;
        if (bus.busy) cnt[C_BUSY]++;
        if (bus.inc_strobe && bus.dec_strobe) cnt[C_BOTH]++;
        if (bus.duty_shadow > 4'd10) cnt[C_RANGE]++;
        if (bus.done) begin
            cnt[C_DONE]++;
            done_at = cyc;
        end
        inc_q = bus.inc_strobe;
        dec_q = bus.dec_strobe;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int d(input int idx);
        return cnt[idx] - base[idx];
    endfunction

    function automatic int rise_at(input int k);
        if (rbase + k < rise_t.size()) return rise_t[rbase + k];
        return -1000;
    endfunction

    task automatic mark();
        base  = cnt;
        rbase = rise_t.size();
    endtask

    task automatic send_target(input int duty, input int ivl);
        bus.target_duty   = 4'(duty);
        bus.step_interval = 16'(ivl);
        bus.target_valid  = 1'b1;
        @(posedge clk); #1;
        bus.target_valid  = 1'b0;
    endtask

    task automatic pulse_manual(input logic inc, input logic dec);
        bus.manual_inc = inc;
        bus.manual_dec = dec;
        @(posedge clk); #1;
        bus.manual_inc = 1'b0;
        bus.manual_dec = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (bus.busy && k < budget);
        check_eq({tag, "_idle"}, 32'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input int inc_r, input int dec_r,
                             input int shadow, input int done_c);
        check_eq({tag, "_inc_rises"}, d(C_INC_R), inc_r);
        check_eq({tag, "_dec_rises"}, d(C_DEC_R), dec_r);
        check_eq({tag, "_shadow"}, 32'(bus.duty_shadow), shadow);
        check_eq({tag, "_done"}, d(C_DONE), done_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        bus.target_valid  = 1'b0;
        bus.target_duty   = '0;
        bus.step_interval = '0;
        bus.manual_inc    = 1'b0;
        bus.manual_dec    = 1'b0;
`ifdef RAMP_ABORT_EN
        bus.abort         = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_ready", 32'(bus.target_ready), 1);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_inc", 32'(bus.inc_strobe), 0);
        check_eq("rst_dec", 32'(bus.dec_strobe), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_shadow", 32'(bus.duty_shadow), 5);

        mark();
        send_target(8, 3);
        wait_idle("t8", 100);
        check_run("t8", 3, 0, 8, 1);
        check_eq("t8_latency", rise_at(0) - acc_n, 4);
        check_eq("t8_period", rise_at(1) - rise_at(0), 11);
        check_eq("t8_inc_hi", d(C_INC_HI), 12);
        check_eq("t8_dec_hi", d(C_DEC_HI), 0);
        check_eq("t8_done_at", done_at - acc_n, 34);

        mark();
        send_target(15, 2);
        wait_idle("t15", 100);
        check_run("t15", 2, 0, 10, 1);
        check_eq("t15_period", rise_at(1) - rise_at(0), 10);

        mark();
        send_target(0, 0);
        wait_idle("t0", 200);
        check_run("t0", 0, 10, 0, 1);
        check_eq("t0_latency", rise_at(0) - acc_n, 2);
        check_eq("t0_period", rise_at(1) - rise_at(0), 9);
        check_eq("t0_dec_hi", d(C_DEC_HI), 40);

        mark();
        send_target(0, 5);
        wait_idle("teq", 20);
        check_run("teq", 0, 0, 0, 1);
        check_eq("teq_done_at", done_at - acc_n, 1);
        check_eq("teq_busy_cycles", d(C_BUSY), 0);
        check_eq("teq_ready", 32'(bus.target_ready), 1);

        mark();
        pulse_manual(1'b0, 1'b1);
        wait_idle("mdec_at0", 20);
        check_run("mdec_at0", 0, 0, 0, 0);

        mark();
        send_target(10, 1);
        wait_idle("up10", 200);
        check_run("up10", 10, 0, 10, 1);

        mark();
        pulse_manual(1'b1, 1'b0);
        wait_idle("minc_at10", 20);
        check_run("minc_at10", 0, 0, 10, 0);

        mark();
        pulse_manual(1'b0, 1'b1);
        wait_idle("mdec_at10", 30);
        check_run("mdec_at10", 0, 1, 9, 1);
        check_eq("mdec_latency", rise_at(0) - man_n, 1);
        check_eq("mdec_dec_hi", d(C_DEC_HI), 4);

        mark();
        pulse_manual(1'b1, 1'b1);
        wait_idle("mboth", 20);
        check_run("mboth", 0, 0, 9, 0);
        check_eq("mboth_busy_cycles", d(C_BUSY), 0);

        mark();
        bus.manual_inc = 1'b1;
        send_target(7, 1);
        bus.manual_inc = 1'b0;
        wait_idle("twins", 60);
        check_run("twins", 0, 2, 7, 1);

        begin
            int k = 0;
            send_target(10, 1);
            while (!bus.inc_strobe && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            check_eq("rstmid_in_pulse", 32'(bus.inc_strobe), 1);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            check_eq("rstmid_inc", 32'(bus.inc_strobe), 0);
            check_eq("rstmid_dec", 32'(bus.dec_strobe), 0);
            check_eq("rstmid_shadow", 32'(bus.duty_shadow), 5);
            check_eq("rstmid_busy", 32'(bus.busy), 0);
            check_eq("rstmid_ready", 32'(bus.target_ready), 1);
            rst = 1'b0;
            @(posedge clk); #1;
        end

`ifdef RAMP_ABORT_EN
        mark();
        send_target(9, 5);
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_eq("abort_busy", 32'(bus.busy), 0);
        wait_idle("abort", 20);
        check_run("abort", 0, 0, 5, 1);
`endif

        check_eq("never_both_strobes", cnt[C_BOTH], 0);
        check_eq("shadow_in_range", cnt[C_RANGE], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
- Sequencer in front of the debounced-button PWM generator.
- Accepts a target duty (0..DUTY_MAX, in 10% steps) and ramps the generator toward it.
- Drives the generator's increase/decrease inputs with paced, debouncer-friendly strobes, one step per interval.
- Keeps a shadow copy of the generator's duty and forwards manual button requests when no ramp is running.

Parameters:
- DUTY_W, 4: width of duty values.
- DUTY_MAX, 10: maximum duty step (100%).
- DUTY_INIT, 5: shadow duty after reset; must match the generator's reset duty.
- INTERVAL_W, 16: width of step_interval.
- PULSE_LEN, 4: cycles each strobe is held high, and also the minimum low gap after it; must be ≥2 so the generator's slow-enable debouncer samples it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- target_valid  in  1  new target offered
- target_duty  in  DUTY_W  requested duty step
- target_ready  out  1  high only in IDLE
- step_interval  in  INTERVAL_W  idle cycles between steps; sampled on target accept
- manual_inc  in  1  one-cycle request to step up
- manual_dec  in  1  one-cycle request to step down
- inc_strobe  out  1  to generator increase input
- dec_strobe  out  1  to generator decrease input
- duty_shadow  out  DUTY_W  current duty as commanded
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a ramp or manual step completes

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: state=IDLE; duty_shadow=DUTY_INIT; inc_strobe=dec_strobe=done=busy=0; target_ready=1.
- States: IDLE, WAIT, PULSE, GAP.
- Target accept:
  - Occurs when target_valid&&target_ready.
  - tgt = min(target_duty, DUTY_MAX).
  - ivl = max(step_interval, 1).
  - If tgt == duty_shadow: stay in IDLE and pulse done the next cycle.
  - Otherwise go to WAIT with the interval counter loaded to ivl.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle it reaches 1, go to PULSE; direction is up if tgt > duty_shadow, else down.
- PULSE entry:
  - duty_shadow ±1.
  - The selected strobe is high for exactly PULSE_LEN cycles; the other strobe stays 0.
- GAP:
  - Both strobes low for PULSE_LEN cycles.
  - Then, if duty_shadow == tgt: go to IDLE and pulse done for 1 cycle.
  - Otherwise go to WAIT with the counter reloaded to ivl.
- Latency, accept to first strobe: ivl+1 cycles.
- Step period: ivl + 2*PULSE_LEN cycles.
- Manual requests:
  - Honoured only in IDLE, and only when target_valid=0 in the same cycle; target wins.
  - manual_inc with duty_shadow < DUTY_MAX sets tgt=duty_shadow+1 and goes directly to PULSE (no WAIT).
  - manual_dec with duty_shadow > 0 behaves symmetrically.
  - Manual request at the boundary (inc at DUTY_MAX, dec at 0) is ignored: no strobe, no done.
  - manual_inc and manual_dec in the same cycle: both ignored.
  - Requests arriving while busy are dropped, not queued.
- Invariants: inc_strobe and dec_strobe are never high together; duty_shadow is never outside [0, DUTY_MAX].
- rst mid-operation: strobes drop the next edge and all registers return to reset values.
  - The generator itself is not reset by this block; integration resets both together.

Optional Feature:
- Macro: RAMP_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort in WAIT: go to IDLE immediately; no strobe; done pulses.
  - abort in PULSE or GAP: the current strobe and gap finish unchanged, then go to IDLE with done; duty_shadow stays consistent.
  - abort in IDLE: ignored.
- When undefined: no abort port; a ramp always runs to tgt.

Decomposition:
- Shared package pwm_ctrl_pkg holds:
  - the state enum (IDLE/WAIT/PULSE/GAP);
  - DUTY_W, DUTY_MAX, DUTY_INIT constants, shared with the generator so the reset duties cannot diverge.
- One sub-module, pwm_strobe_timer: loadable down-counter used for both the interval countdown and the PULSE_LEN pulse/gap timing.
  - Ports: load, load_val, tick, zero.

Test Plan:
- Reset, then target 8 with interval 3 → three inc strobes of 4 cycles each, first rising 4 cycles after accept, period 11 cycles; duty_shadow 5→8; done once; no dec_strobe.
- Target 15 from shadow 8 → clamped; two inc steps; shadow ends at 10.
- Target 0 with interval 0 → treated as interval 1; 10 dec steps; shadow ends at 0.
- Target equal to the shadow → no strobes; done one cycle after accept; target_ready stays 1.
- Manual cases:
  - manual_inc at shadow 10 → ignored.
  - manual_dec at shadow 10 → one dec strobe; shadow 9; done.
  - manual_inc and manual_dec together → nothing happens.
  - target_valid together with a manual request → target wins.
- rst asserted in the middle of a PULSE → strobes go to 0 the next cycle; shadow returns to 5.
- With RAMP_ABORT_EN: abort asserted during WAIT → IDLE next cycle, no strobe.
